// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared defaults and control-word field indices for the control pipe chain
package ctrl_pipe_pkg;

    localparam int DEF_COUNT_W    = 16;
    localparam int DEF_BUBBLE_VAL = 0;

    // Bit positions of the decoded MIPS control word
    localparam int MEMTOREG = 0;
    localparam int MEMWRITE = 1;
    localparam int REGWRITE = 2;
    localparam int MEMREAD  = 3;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - one control-word register with flush/hold/bubble/load select
module ctrl_pipe_stage #(
    parameter int           W          = 4,
    parameter logic [W-1:0] BUBBLE_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d_ctrl,
    input  logic         d_valid,
    output logic [W-1:0] q_ctrl,
    output logic         q_valid
);

    // Flush beats hold; hold beats bubble insertion from a frozen upstream stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_ctrl  <= BUBBLE_VAL;
            q_valid <= 1'b0;
        end else if (flush) begin
            q_ctrl  <= BUBBLE_VAL;
            q_valid <= 1'b0;
        end else if (hold) begin
            q_ctrl  <= q_ctrl;
            q_valid <= q_valid;
        end else if (bubble) begin
            q_ctrl  <= BUBBLE_VAL;
            q_valid <= 1'b0;
        end else begin
            q_ctrl  <= d_ctrl;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// rtl/ctrl_pipe_chain.sv - multi-stage control-word carrier with stall/flush and bubble counter
module ctrl_pipe_chain
    import ctrl_pipe_pkg::*;
#(
    parameter int           W          = 4,
    parameter int           STAGES     = 3,
    parameter logic [W-1:0] BUBBLE_VAL = W'(DEF_BUBBLE_VAL),
    parameter int           COUNT_W    = DEF_COUNT_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [W-1:0]          i_ctrl,
    input  logic                  i_valid,
    input  logic [STAGES-1:0]     i_stall,
    input  logic [STAGES-1:0]     i_flush,
    output logic [STAGES*W-1:0]   o_ctrl,
    output logic [STAGES-1:0]     o_valid,
    output logic                  o_ready,
    output logic [COUNT_W-1:0]    o_bubble_cnt
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] up_hold;
    logic [W-1:0]      src_ctrl  [STAGES];
    logic [STAGES-1:0] src_valid;

    assign o_ready = ~hold[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // A stall anywhere downstream freezes this stage as well
        assign hold[k] = |(i_stall >> k);

        if (k == 0) begin : g_head
            assign src_ctrl[k]  = i_ctrl;
            assign src_valid[k] = i_valid;
            assign up_hold[k]   = 1'b0;
        end else begin : g_body
            assign src_ctrl[k]  = o_ctrl[(k-1)*W +: W];
            assign src_valid[k] = o_valid[k-1];
            assign up_hold[k]   = hold[k-1];
        end

        ctrl_pipe_stage #(
            .W          (W),
            .BUBBLE_VAL (BUBBLE_VAL)
        ) u_stage (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .flush   (i_flush[k]),
            .hold    (hold[k]),
            .bubble  (up_hold[k]),
            .d_ctrl  (src_ctrl[k]),
            .d_valid (src_valid[k]),
            .q_ctrl  (o_ctrl[k*W +: W]),
            .q_valid (o_valid[k])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bubble_cnt <= '0;
        end else if (!o_valid[STAGES-1] && (o_bubble_cnt != {COUNT_W{1'b1}})) begin
            o_bubble_cnt <= o_bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb/tb_ctrl_pipe_chain.sv - scoreboard bench for ctrl_pipe_chain against a reference model
module tb_ctrl_pipe_chain;

    localparam int W       = 4;
    localparam int STAGES  = 3;
    localparam int COUNT_W = 3;
    localparam int CNT_MAX = (1 << COUNT_W) - 1;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic [W-1:0]         i_ctrl;
    logic                 i_valid;
    logic [STAGES-1:0]    i_stall;
    logic [STAGES-1:0]    i_flush;
    logic [STAGES*W-1:0]  o_ctrl;
    logic [STAGES-1:0]    o_valid;
    logic                 o_ready;
    logic [COUNT_W-1:0]   o_bubble_cnt;

    ctrl_pipe_chain #(
        .W          (W),
        .STAGES     (STAGES),
        .BUBBLE_VAL (4'h0),
        .COUNT_W    (COUNT_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_ctrl       (i_ctrl),
        .i_valid      (i_valid),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .o_ctrl       (o_ctrl),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
        .o_bubble_cnt (o_bubble_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic                rdy;
        logic [STAGES*W-1:0] ctrl;
        logic [STAGES-1:0]   val;
        int                  cnt;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    logic [W-1:0] m_w [STAGES];
    logic         m_v [STAGES];
    int           m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < STAGES; k++) begin
            m_w[k] = '0;
            m_v[k] = 1'b0;
        end
        m_cnt = 0;
    endtask

    // Drive one cycle at the falling edge and push the state expected after the next rising edge
    task automatic cycle(input logic [W-1:0] c, input logic v,
                         input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl);
        logic [W-1:0] nw [STAGES];
        logic         nv [STAGES];
        logic         h  [STAGES];
        exp_t         e;
        @(negedge i_clk);
        i_ctrl  = c;
        i_valid = v;
        i_stall = st;
        i_flush = fl;
        for (int k = 0; k < STAGES; k++) h[k] = ((st >> k) != 0);
        for (int k = 0; k < STAGES; k++) begin
            if (fl[k]) begin
                nw[k] = '0; nv[k] = 1'b0;
            end else if (h[k]) begin
                nw[k] = m_w[k]; nv[k] = m_v[k];
            end else if (k > 0 && h[k-1]) begin
                nw[k] = '0; nv[k] = 1'b0;
            end else if (k == 0) begin
                nw[k] = c; nv[k] = v;
            end else begin
                nw[k] = m_w[k-1]; nv[k] = m_v[k-1];
            end
        end
        e.rdy = !h[0];
        if (!m_v[STAGES-1] && m_cnt < CNT_MAX) m_cnt++;
        for (int k = 0; k < STAGES; k++) begin
            m_w[k] = nw[k];
            m_v[k] = nv[k];
            e.ctrl[k*W +: W] = nw[k];
            e.val[k]         = nv[k];
        end
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    always @(posedge i_clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ready", int'(o_ready), int'(e.rdy));
            chk("ctrl",  int'(o_ctrl),  int'(e.ctrl));
            chk("valid", int'(o_valid), int'(e.val));
            chk("bubble_cnt", int'(o_bubble_cnt), e.cnt);
        end
    end

    initial begin
        i_rst_n = 1'b0;
        i_ctrl  = '0;
        i_valid = 1'b0;
        i_stall = '0;
        i_flush = '0;
        model_reset();
        #3;
        chk("reset_ctrl",  int'(o_ctrl), 0);
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_cnt",   int'(o_bubble_cnt), 0);
        #5 i_rst_n = 1'b1;

        // Counter saturation on idle cycles
        for (int i = 0; i < 10; i++) cycle(4'h0, 1'b0, 3'b000, 3'b000);

        // Streaming A,B,C
        cycle(4'hA, 1'b1, 3'b000, 3'b000);
        cycle(4'hB, 1'b1, 3'b000, 3'b000);
        cycle(4'hC, 1'b1, 3'b000, 3'b000);
        cycle(4'h0, 1'b0, 3'b000, 3'b000);
        cycle(4'h0, 1'b0, 3'b000, 3'b000);

        // Stall at stage 1 with D offered and dropped
        cycle(4'hA, 1'b1, 3'b000, 3'b000);
        cycle(4'hB, 1'b1, 3'b000, 3'b000);
        cycle(4'hC, 1'b1, 3'b000, 3'b000);
        cycle(4'hD, 1'b1, 3'b010, 3'b000);
        cycle(4'hD, 1'b1, 3'b010, 3'b000);
        cycle(4'h0, 1'b0, 3'b000, 3'b000);
        cycle(4'h0, 1'b0, 3'b000, 3'b000);

        // Branch flush on a full pipe
        cycle(4'hA, 1'b1, 3'b000, 3'b000);
        cycle(4'hB, 1'b1, 3'b000, 3'b000);
        cycle(4'hC, 1'b1, 3'b000, 3'b000);
        cycle(4'hE, 1'b1, 3'b000, 3'b011);
        cycle(4'h0, 1'b0, 3'b000, 3'b000);

        // Flush and stall on the same stage
        cycle(4'h5, 1'b1, 3'b000, 3'b000);
        cycle(4'h6, 1'b1, 3'b000, 3'b000);
        cycle(4'h7, 1'b1, 3'b010, 3'b010);
        cycle(4'h8, 1'b1, 3'b000, 3'b000);

        // Flush of stage 0 while accepting discards the incoming word
        cycle(4'h9, 1'b1, 3'b000, 3'b001);

        for (int i = 0; i < 300; i++)
            cycle(4'($urandom), 1'($urandom), 3'($urandom_range(0, 7) & $urandom_range(0, 7)),
                  3'(($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0));

        // Asynchronous reset in the middle of a full stall
        cycle(4'h3, 1'b1, 3'b111, 3'b000);
        cycle(4'h4, 1'b1, 3'b111, 3'b000);
        @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl",  int'(o_ctrl), 0);
        chk("async_rst_valid", int'(o_valid), 0);
        chk("async_rst_cnt",   int'(o_bubble_cnt), 0);
        model_reset();
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        cycle(4'hA, 1'b1, 3'b000, 3'b000);
        cycle(4'h1, 1'b1, 3'b000, 3'b000);

        for (int i = 0; i < 200; i++)
            cycle(4'($urandom), 1'($urandom), 3'($urandom_range(0, 7) & $urandom_range(0, 7)),
                  3'(($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 0));

        @(posedge i_clk);
        #3;
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
